// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch sequencer for the LegV8 64-bit core. Owns the program
//   counter, addresses a combinational instruction ROM, and holds each fetched
//   word in a valid/ready output stage for decode. Execute can redirect it
//   with a branch. Fetch stops when the halt word is read. Halt is reported
//   after decode accepts that word.
//
// Ports
//   clock          in   1   single clock, rising edge
//   reset          in   1   asynchronous, active-high
//   rom_address    out 16   ROM word address = pc[17:2] (combinational)
//   rom_data       in  32   ROM word at rom_address, same cycle
//   instr          out 32   registered instruction for decode
//   instr_pc       out 64   byte address of instr
//   instr_valid    out  1   instr/instr_pc hold a live instruction
//   instr_ready    in   1   decode accepts instr this cycle
//   branch_taken   in   1   redirect request from execute
//   branch_target  in  64   byte target, bits [1:0] ignored
//   halted         out  1   high while in HALTED
//   fetch_count    out 32   saturating count of handshakes
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_WORD = 32'hD60003E0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic [63:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_halted;
    logic [31:0] r_fetch_count;

    logic        w_handshake;
    logic        w_slot_free;
    logic        w_is_halt;

    assign w_handshake = r_instr_valid & instr_ready;
    assign w_slot_free = ~r_instr_valid | w_handshake;
    assign w_is_halt   = (rom_data == HALT_WORD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_pc    <= 64'h0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            // Counting is independent of redirects: an instruction accepted in
            // the same cycle as a branch has still been consumed by decode.
            if (w_handshake && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (branch_taken) begin
                // Redirect kills the output slot and skips the ROM load this
                // edge; the target word is presented on the following edge.
                r_pc          <= {branch_target[63:2], 2'b00};
                r_instr_valid <= 1'b0;
                r_state       <= RUN;
                r_halted      <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_slot_free) begin
                            r_instr       <= rom_data;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            // The PC parks on the halt word so rom_address
                            // keeps pointing at it while drained/halted.
                            if (w_is_halt) begin
                                r_state <= DRAIN;
                            end else begin
                                r_pc <= r_pc + 64'd4;
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_handshake) begin
                            r_instr_valid <= 1'b0;
                            r_state       <= HALTED;
                            r_halted      <= 1'b1;
                        end
                    end
                    HALTED: begin
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end
                    default: begin
                        r_state       <= RUN;
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_address = r_pc[17:2];
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer: sequential fetch, stall, branch with a
//   misaligned target, halt and restart, and reset asserted while draining.
//   A small combinational ROM model holds the copy program; every location
//   past the program reads the halt fill word.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hD60003E0;

    logic        clock;
    logic        reset;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [0:15];

    int n_checks;
    int n_pass;

    fetch_sequencer #(
        .RESET_PC  (64'h0),
        .HALT_WORD (HALT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rom_data = (rom_address < 16'd16) ? rom[rom_address[3:0]] : HALT;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-22s got %h", tag, got);
        end else begin
            $display("FAIL %-22s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Assert reset, check the asynchronous reset values, release between edges.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 64'(instr_valid), 64'd0);
        check({tag, "_rst_count"}, 64'(fetch_count), 64'd0);
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;

        rom[0]  = 32'h910193E4;
        rom[1]  = 32'h910003E5;
        rom[2]  = 32'hF8400080;
        rom[3]  = 32'hB4000100;
        rom[4]  = 32'hF80000A0;
        rom[5]  = 32'h91002084;
        rom[6]  = 32'h910020A5;
        rom[7]  = 32'hD1000400;
        rom[8]  = 32'hB5FFFF00;
        rom[9]  = 32'h17FFFFF9;
        for (int i = 10; i < 16; i++) rom[i] = HALT;

        // ---------------- Sequential fetch, halt, restart ----------------
        #2;
        check("rst_instr",    64'(instr),       64'h0);
        check("rst_instr_pc", instr_pc,         64'h0);
        check("rst_valid",    64'(instr_valid), 64'd0);
        check("rst_halted",   64'(halted),      64'd0);
        check("rst_count",    64'(fetch_count), 64'd0);
        check("rst_rom_addr", 64'(rom_address), 64'd0);
        steps(1);
        reset       = 1'b0;
        instr_ready = 1'b1;

        step(); // edge 1
        check("seq_e1_instr", 64'(instr),       64'h910193E4);
        check("seq_e1_pc",    instr_pc,         64'h0);
        check("seq_e1_valid", 64'(instr_valid), 64'd1);
        steps(9); // edge 10
        check("seq_e10_instr", 64'(instr), 64'h17FFFFF9);
        check("seq_e10_pc",    instr_pc,   64'h24);
        step();   // edge 11: tenth handshake, halt word loaded
        check("seq_count10",  64'(fetch_count), 64'd10);
        check("halt_instr",   64'(instr),       64'(HALT));
        check("halt_pc",      instr_pc,         64'h28);
        check("halt_not_yet", 64'(halted),      64'd0);
        step();   // edge 12: halt word accepted
        check("halt_halted",  64'(halted),      64'd1);
        check("halt_valid",   64'(instr_valid), 64'd0);
        check("halt_count",   64'(fetch_count), 64'd11);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("halt_hold%0d", i),
                  {46'h0, halted, instr_valid, rom_address}, {46'h0, 1'b1, 1'b0, 16'd10});
        end

        branch_taken  = 1'b1;
        branch_target = 64'h0;
        step();
        branch_taken = 1'b0;
        check("restart_halted", 64'(halted),      64'd0);
        check("restart_valid",  64'(instr_valid), 64'd0);
        step();
        check("restart_instr", 64'(instr),       64'h910193E4);
        check("restart_pc",    instr_pc,         64'h0);
        check("restart_count", 64'(fetch_count), 64'd11);

        // ---------------- Stall and branch ----------------
        do_reset("b");
        steps(3); // edges 1..3 present 0x0, 0x4, 0x8
        check("stall_pc_in", instr_pc, 64'h8);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_instr%0d", i), 64'(instr),       64'hF8400080);
            check($sformatf("stall_pc%0d", i),    instr_pc,         64'h8);
            check($sformatf("stall_addr%0d", i),  64'(rom_address), 64'd3);
        end
        instr_ready = 1'b1;
        step();
        check("stall_rel_pc",    instr_pc,         64'hC);
        check("stall_rel_instr", 64'(instr),       64'hB4000100);
        check("stall_rel_count", 64'(fetch_count), 64'd3);
        steps(6);
        check("br_pre_pc", instr_pc, 64'h24);
        branch_taken  = 1'b1;
        branch_target = 64'hE;
        step();
        branch_taken = 1'b0;
        check("br_valid", 64'(instr_valid), 64'd0);
        check("br_count", 64'(fetch_count), 64'd10);
        check("br_addr",  64'(rom_address), 64'd3);
        step();
        check("br_tgt_pc",    instr_pc,         64'hC);
        check("br_tgt_instr", 64'(instr),       64'hB4000100);
        check("br_tgt_valid", 64'(instr_valid), 64'd1);

        // ---------------- Reset mid-DRAIN ----------------
        do_reset("c");
        steps(11);
        instr_ready = 1'b0;
        check("drain_instr", 64'(instr), 64'(HALT));
        step();
        check("drain_valid",  64'(instr_valid), 64'd1);
        check("drain_halted", 64'(halted),      64'd0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_instr",  64'(instr),       64'h0);
        check("mid_rst_pc",     instr_pc,         64'h0);
        check("mid_rst_valid",  64'(instr_valid), 64'd0);
        check("mid_rst_halted", 64'(halted),      64'd0);
        check("mid_rst_count",  64'(fetch_count), 64'd0);
        check("mid_rst_addr",   64'(rom_address), 64'd0);
        #1;
        reset       = 1'b0;
        instr_ready = 1'b1;
        step();
        check("post_rst_pc",    instr_pc,         64'h0);
        check("post_rst_valid", 64'(instr_valid), 64'd1);
        check("post_rst_count", 64'(fetch_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
